// File: rtl/id_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// id_dispatch_pkg
// Shared types for the decoded-instruction dispatch queue:
//   - dispatch_state_t : scheduler FSM states (RUN, DRAIN, SOLO)
//   - hazard_fields_t  : the per-instruction register/serialisation fields
//                        used for the intra-pair issue check
//   - CNT_W            : occupancy width for the default 8-entry queue
// -----------------------------------------------------------------------------
package id_dispatch_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_DEPTH) + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SOLO  = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic       wen;
        logic [4:0] waddr;
        logic       r1en;
        logic [4:0] r1addr;
        logic       r2en;
        logic [4:0] r2addr;
        logic       serial;
    } hazard_fields_t;

endpackage

// File: rtl/id_dispatch_hazard.sv
// -----------------------------------------------------------------------------
// id_dispatch_hazard
// Combinational pair check: decides whether the younger instruction may issue
// in the same cycle as the older one.
// Ports:
//   older   in  hazard fields of the head entry
//   younger in  hazard fields of head+1
//   dual_ok out 1 when neither entry is serialising and there is no RAW/WAW
//               dependency of the younger on the older's destination
// -----------------------------------------------------------------------------
module id_dispatch_hazard
    import id_dispatch_pkg::*;
(
    input  hazard_fields_t older,
    input  hazard_fields_t younger,
    output logic           dual_ok
);

    logic writes_real_reg;
    logic raw_or_waw;

    // Writes to r0 are discarded by the register file, so they never create
    // a dependency for the younger instruction.
    always_comb begin
        writes_real_reg = older.wen && (older.waddr != 5'd0);
        raw_or_waw      = writes_real_reg &&
                          ((younger.r1en && (younger.r1addr == older.waddr)) ||
                           (younger.r2en && (younger.r2addr == older.waddr)) ||
                           (younger.wen  && (younger.waddr  == older.waddr)));
        dual_ok         = !older.serial && !younger.serial && !raw_or_waw;
    end

endmodule

// File: rtl/id_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// id_dispatch_ctrl
// Decoded-instruction queue and in-order dual-issue scheduler sitting between
// the two-slot decode stage and issue/execute.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard queue contents and return to RUN
//   enq_valid[1:0]    decode slot valids (bit0 older); compacted on write
//   enq_ready         room for two more entries (registered count only)
//   enq_payload/...   per-slot payload and register/serial fields
//   backend_idle      nothing in flight past issue
//   serial_done       pulse: the serialised instruction has committed
//   issue_ready       backend accepts this cycle's issue
//   issue_valid[1:0]  bit0 = head, bit1 = head+1
//   issue_payload     payloads of head and head+1
//   occupancy         registered entry count
// -----------------------------------------------------------------------------
module id_dispatch_ctrl
    import id_dispatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              enq_valid,
    output logic                    enq_ready,
    input  logic [1:0][DW-1:0]      enq_payload,
    input  logic [1:0]              enq_wen,
    input  logic [1:0][4:0]         enq_waddr,
    input  logic [1:0]              enq_r1en,
    input  logic [1:0]              enq_r2en,
    input  logic [1:0][4:0]         enq_r1addr,
    input  logic [1:0][4:0]         enq_r2addr,
    input  logic [1:0]              enq_serial,
    input  logic                    backend_idle,
    input  logic                    serial_done,
    input  logic                    issue_ready,
    output logic [1:0]              issue_valid,
    output logic [1:0][DW-1:0]      issue_payload,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DW-1:0]      pay_mem [DEPTH];
    hazard_fields_t     fld_mem [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head1;
    logic [PTR_W-1:0]   tail1;
    logic [OCC_W-1:0]   count;
    logic [OCC_W-1:0]   count_nxt;
    dispatch_state_t    state;
    dispatch_state_t    state_nxt;

    hazard_fields_t     slot_fld [2];
    hazard_fields_t     wr0_fld;
    logic [DW-1:0]      wr0_pay;
    logic               wr0;
    logic               wr1;
    logic [1:0]         enq_num;
    logic [1:0]         deq_num;

    hazard_fields_t     h0;
    hazard_fields_t     h1;
    logic               dual_ok;
    logic               head_ok;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);
    assign h0    = fld_mem[head];
    assign h1    = fld_mem[head1];

    assign enq_ready     = (count <= OCC_W'(DEPTH - 2));
    assign occupancy     = count;
    assign issue_payload = {pay_mem[head1], pay_mem[head]};

    id_dispatch_hazard u_hazard (
        .older   (h0),
        .younger (h1),
        .dual_ok (dual_ok)
    );

    // Gather the decode-slot fields and compact them: a lone valid slot (either
    // one) always lands at tail, and slot 1 goes to tail+1 only for a pair.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            slot_fld[s] = '{wen:    enq_wen[s],
                            waddr:  enq_waddr[s],
                            r1en:   enq_r1en[s],
                            r1addr: enq_r1addr[s],
                            r2en:   enq_r2en[s],
                            r2addr: enq_r2addr[s],
                            serial: enq_serial[s]};
        end
        wr0_fld = enq_valid[0] ? slot_fld[0]    : slot_fld[1];
        wr0_pay = enq_valid[0] ? enq_payload[0] : enq_payload[1];
        wr0     = enq_ready && (enq_valid != 2'b00);
        wr1     = enq_ready && (enq_valid == 2'b11);
        enq_num = {1'b0, wr0} + {1'b0, wr1};
    end

    // Issue selection. In RUN a non-serial head goes straight out and a serial
    // head waits for an idle backend; in DRAIN only the serial head can go, and
    // only once the backend is idle. Nothing issues in SOLO. The pair slot is
    // never used for serialising instructions (dual_ok already excludes them).
    always_comb begin
        issue_valid = 2'b00;
        head_ok     = 1'b0;
        if (count != '0) begin
            case (state)
                RUN:     head_ok = !h0.serial || backend_idle;
                DRAIN:   head_ok = backend_idle;
                default: head_ok = 1'b0;
            endcase
        end
        issue_valid[0] = head_ok;
        issue_valid[1] = head_ok && (state == RUN) && (count > OCC_W'(1)) && dual_ok;
        deq_num        = issue_ready ? ({1'b0, issue_valid[0]} + {1'b0, issue_valid[1]}) : 2'd0;
        count_nxt      = count + OCC_W'(enq_num) - OCC_W'(deq_num);
    end

    // Serialisation FSM. A serial head either waits in DRAIN for the backend to
    // empty, or issues directly when it is already idle; after it issues, SOLO
    // holds off all younger issue until the commit pulse arrives.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if ((count != '0) && h0.serial) begin
                    if (!backend_idle) begin
                        state_nxt = DRAIN;
                    end else if (issue_ready) begin
                        state_nxt = SOLO;
                    end
                end
            end
            DRAIN: begin
                if (backend_idle && issue_ready) begin
                    state_nxt = SOLO;
                end
            end
            SOLO: begin
                if (serial_done) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Pointer, count and state registers. Flush behaves exactly like reset and
    // swallows any enqueue or issue happening in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else begin
            head  <= head + PTR_W'(deq_num);
            tail  <= tail + PTR_W'(enq_num);
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // Entry storage has no reset; contents are only meaningful between head
    // and tail, and writes are suppressed during reset/flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (wr0) begin
                pay_mem[tail] <= wr0_pay;
                fld_mem[tail] <= wr0_fld;
            end
            if (wr1) begin
                pay_mem[tail1] <= enq_payload[1];
                fld_mem[tail1] <= slot_fld[1];
            end
        end
    end

endmodule
